// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch predictor
package bp_pkg;

    localparam int ENTRIES_DEFAULT = 16;
    // Widest tag, reached at the smallest table (4 entries); narrower tags are zero-extended.
    localparam int TAG_MAX = 28;

    typedef logic [1:0] bp_cnt_t;

    localparam bp_cnt_t SNT = 2'b00;
    localparam bp_cnt_t WNT = 2'b01;
    localparam bp_cnt_t WT  = 2'b10;
    localparam bp_cnt_t ST  = 2'b11;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
        bp_cnt_t            cnt;
    } bp_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating counter next-state logic
module sat_counter2
    import bp_pkg::*;
(
    input  bp_cnt_t cnt,
    input  logic    taken,
    output bp_cnt_t cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != ST) cnt_next = cnt + 2'd1;
        end else begin
            if (cnt != SNT) cnt_next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit branch predictor with target buffer
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    output logic        PredictTakenF,
    output logic [31:0] PredictedPCF,
    input  logic        BranchE,
    input  logic [31:0] PCE,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        PredictedTakenE,
    input  logic        CorrectAddrE,
    output logic        MispredictE,
    output logic [31:0] RecoverPCE
`ifdef BP_STATS_EN
    ,
    output logic [31:0] BranchCount,
    output logic [31:0] MispredictCount
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_entry_t        table_q [ENTRIES];
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_e;
    bp_entry_t        entry_f;
    bp_entry_t        entry_e;
    logic             hit_e;
    bp_cnt_t          cnt_next;

    function automatic logic [TAG_MAX-1:0] tag_of(input logic [31:0] pc);
        return TAG_MAX'(pc >> (2 + IDX_W));
    endfunction

    assign idx_f   = PCF[IDX_W+1:2];
    assign idx_e   = PCE[IDX_W+1:2];
    assign entry_f = table_q[idx_f];
    assign entry_e = table_q[idx_e];

    // Lookup reads registered state only, so a same-cycle write is never forwarded.
    assign PredictTakenF = entry_f.valid && (entry_f.tag == tag_of(PCF)) && entry_f.cnt[1];
    assign PredictedPCF  = PredictTakenF ? entry_f.target : 32'd0;

    assign hit_e = entry_e.valid && (entry_e.tag == tag_of(PCE));

    sat_counter2 u_sat_counter2 (
        .cnt      (entry_e.cnt),
        .taken    (BranchTakenE),
        .cnt_next (cnt_next)
    );

    assign MispredictE = BranchE & ((PredictedTakenE != BranchTakenE) |
                                    (PredictedTakenE & BranchTakenE & ~CorrectAddrE));
    assign RecoverPCE  = BranchTakenE ? BranchTargetE : PCE + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, cnt: WNT};
            end
        end else if (BranchE) begin
            if (hit_e) begin
                table_q[idx_e].cnt <= cnt_next;
                if (BranchTakenE) table_q[idx_e].target <= BranchTargetE;
            end else if (BranchTakenE) begin
                table_q[idx_e] <= '{valid: 1'b1, tag: tag_of(PCE), target: BranchTargetE, cnt: WT};
            end
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BranchCount     <= 32'd0;
            MispredictCount <= 32'd0;
        end else begin
            if (BranchE)     BranchCount     <= BranchCount + 32'd1;
            if (MispredictE) MispredictCount <= MispredictCount + 32'd1;
        end
    end
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped predictor entries (power of two, 4..64).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port PCF, input, 32, fetch-stage PC to predict.
REQ-005 SHALL have port PredictTakenF, output, 1, fetch-stage prediction that the branch is taken.
REQ-006 SHALL have port PredictedPCF, output, 32, predicted target, valid when PredictTakenF=1, else 0.
REQ-007 SHALL have port BranchE, input, 1, execute stage holds a resolved branch.
REQ-008 SHALL have port PCE, input, 32, PC of the execute-stage branch.
REQ-009 SHALL have port BranchTakenE, input, 1, actual branch outcome.
REQ-010 SHALL have port BranchTargetE, input, 32, actual branch target computed by the ALU.
REQ-011 SHALL have port PredictedTakenE, input, 1, PredictTakenF carried down the pipeline with this branch.
REQ-012 SHALL have port CorrectAddrE, input, 1, ALU address-check result for this branch.
REQ-013 SHALL have port MispredictE, output, 1, flush request for fetch and decode.
REQ-014 SHALL have port RecoverPCE, output, 32, PC to refetch when MispredictE=1.

Function
REQ-015 SHALL give each entry a valid bit, tag PC[31:2+log2(ENTRIES)], 32-bit target and 2-bit saturating counter; index = PC[1+log2(ENTRIES):2].
REQ-016 SHALL perform lookup combinationally from registered state, zero-cycle latency.
REQ-017 SHALL assert PredictTakenF only when the entry is valid, the tag matches and counter[1]=1.
REQ-018 SHALL update state on the clock edge when BranchE=1, one entry per cycle; no update when BranchE=0.
REQ-019 SHALL on hit increment the counter when taken (saturating at 11) and decrement it when not taken (saturating at 00); when taken, target SHALL be overwritten with BranchTargetE.
REQ-020 SHALL on miss with BranchTakenE=1 allocate and replace: valid=1, new tag, target=BranchTargetE, counter=10.
REQ-021 SHALL on miss with BranchTakenE=0 leave the entry untouched.
REQ-022 SHALL NOT bypass updates: a lookup of the index being written in the same cycle returns pre-update contents.
REQ-023 SHALL drive MispredictE = BranchE & ((PredictedTakenE != BranchTakenE) | (PredictedTakenE & BranchTakenE & ~CorrectAddrE)), combinationally.
REQ-024 SHALL drive RecoverPCE = BranchTargetE when BranchTakenE=1, else PCE+4 (32-bit wrap, 0xFFFFFFFC+4 = 0).
REQ-025 SHALL treat a misprediction like any other update; the entry is still trained.

Reset
REQ-026 SHALL on reset clear all valid bits, set all counters to 01 and targets/tags to 0, asynchronously.
REQ-027 SHALL drive PredictTakenF=0 and PredictedPCF=0 during and after reset until an allocation.
REQ-028 SHALL discard an update coinciding with reset; reset wins.

Configuration
REQ-029 SHALL with BP_STATS_EN defined add outputs BranchCount[31:0] and MispredictCount[31:0]; these count BranchE and MispredictE cycles, wrap at 2^32 and reset to 0.
REQ-030 SHALL without BP_STATS_EN have neither these ports nor their counters.

Structure
REQ-031 SHALL place the ENTRIES default, the 2-bit counter typedef, its constants (SNT=00, WNT=01, WT=10, ST=11) and the entry struct in package bp_pkg.
REQ-032 SHALL implement the counter update in sub-module sat_counter2 (inputs cnt, taken; output next cnt).

Verification
REQ-033 SHALL check reset: after reset, PCF=0x100 -> PredictTakenF=0, PredictedPCF=0.
REQ-034 SHALL check allocation: branch PCE=0x100 taken to 0x200 with PredictedTakenE=0 -> MispredictE=1, RecoverPCE=0x200; next cycle PCF=0x100 -> PredictTakenF=1, PredictedPCF=0x200.
REQ-035 SHALL check hysteresis: from 10, one not-taken at 0x100 -> counter 01, PredictTakenF=0, RecoverPCE=0x104; a further two taken -> 11; one not-taken -> still predicts taken.
REQ-036 SHALL check aliasing: with ENTRIES=16, taken branch at 0x140 evicts 0x100 (same index) -> PCF=0x100 gives PredictTakenF=0.
REQ-037 SHALL check the wrong target: PredictedTakenE=1, BranchTakenE=1, CorrectAddrE=0, BranchTargetE=0x300 -> MispredictE=1, RecoverPCE=0x300, entry target becomes 0x300.
REQ-038 SHALL check the same-cycle update and lookup of index 0 plus BP_STATS_EN counts: the lookup sees old data; 3 branches with 1 mispredict -> BranchCount=3, MispredictCount=1.
